// File: rtl/fir_transpose.sv
// ----------------------------------------------------------------------------
// fir_transpose
//   Transposed-form FIR filter for 12-bit signed samples, one sample per Clk.
//   Coefficients live in an internal register bank. They are written through
//   the load port and read back combinationally through the read port.
//
//   Ports
//     Clk            rising-edge clock
//     Hlt            asynchronous active-low reset of the datapath (delay
//                    line and Dout); the coefficient bank is not reset
//     Din   [11:0]   signed input sample, taken on every rising Clk
//     Dout  [11:0]   signed filtered output, registered
//     write_address  coefficient write index (indices >= NTAPS are ignored)
//     write_value    signed coefficient written when load=1
//     load           coefficient write enable, honoured even while Hlt=0
//     read_address   coefficient read index
//     read_value     h[read_address], or 0 if the index is >= NTAPS
//
//   Parameters
//     NTAPS      number of taps (1..256)
//     COEF_FRAC  fractional bits of the coefficients (output shift)
//
//   Build option
//     SATURATE_EN  when defined, the scaled output is clamped to
//                  [-2048, 2047]. Otherwise the low 12 bits are kept,
//                  so the output wraps in two's complement.
// ----------------------------------------------------------------------------
module fir_transpose #(
    parameter int unsigned NTAPS     = 16,
    parameter int unsigned COEF_FRAC = 11
) (
    input  logic        Clk,
    input  logic        Hlt,
    input  logic [11:0] Din,
    output logic [11:0] Dout,
    input  logic [7:0]  write_address,
    input  logic [11:0] write_value,
    input  logic        load,
    input  logic [7:0]  read_address,
    output logic [11:0] read_value
);

    localparam int unsigned DW     = 12;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned PW     = 2 * DW;
    localparam int unsigned AW     = PW + $clog2(NTAPS);
    // Delay-line depth. The slot z_q[k] holds the partial sum of tap k+1.
    localparam int unsigned ZN     = (NTAPS > 1) ? NTAPS - 1 : 1;

    // ------------------------------------------------------------------
    // Coefficient bank
    // ------------------------------------------------------------------
    logic [DW-1:0] h_q [NTAPS];
    logic [DW-1:0] h_d [NTAPS];

    // Address decode for the write. Indices beyond the bank match no entry.
    always_comb begin
        for (int unsigned k = 0; k < NTAPS; k++) begin
            h_d[k] = h_q[k];
            if (load && (write_address == ADDR_W'(k))) begin
                h_d[k] = write_value;
            end
        end
    end

    // No reset on purpose: the coefficients survive Hlt.
    always_ff @(posedge Clk) begin
        for (int unsigned k = 0; k < NTAPS; k++) begin
            h_q[k] <= h_d[k];
        end
    end

    // Combinational read-back. Out-of-range indices read as zero.
    always_comb begin
        read_value = '0;
        for (int unsigned k = 0; k < NTAPS; k++) begin
            if (read_address == ADDR_W'(k)) begin
                read_value = h_q[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Products: p[k] = h[k] * Din. Both operands are sign-extended to the
    // full product width, so the low PW bits are exact.
    // ------------------------------------------------------------------
    logic signed [PW-1:0] p_c [NTAPS];

    always_comb begin
        for (int unsigned k = 0; k < NTAPS; k++) begin
            p_c[k] = PW'($signed(h_q[k])) * PW'($signed(Din));
        end
    end

    // ------------------------------------------------------------------
    // Transposed delay line and output sum
    // ------------------------------------------------------------------
    logic signed [AW-1:0] z_q [ZN];
    logic signed [AW-1:0] z_d [ZN];
    logic signed [AW-1:0] acc_c;

    if (NTAPS > 1) begin : g_chain
        // Each slot adds its own product to the slot behind it.
        // The last tap only loads its product.
        always_comb begin
            for (int unsigned k = 0; k < ZN; k++) begin
                z_d[k] = '0;
            end
            for (int unsigned k = 0; k + 1 < ZN; k++) begin
                z_d[k] = AW'(p_c[k + 1]) + z_q[k + 1];
            end
            z_d[ZN - 1] = AW'(p_c[ZN]);
            acc_c       = AW'(p_c[0]) + z_q[0];
        end
    end else begin : g_single
        // A single tap has no history. The output is just the product.
        always_comb begin
            z_d[0] = '0;
            acc_c  = AW'(p_c[0]);
        end
    end

    // ------------------------------------------------------------------
    // Output scaling: an arithmetic shift (floor), then clamp or wrap
    // ------------------------------------------------------------------
    logic signed [AW-1:0] scaled_c;
    logic [DW-1:0]        dout_d;
    logic [DW-1:0]        dout_q;

    always_comb begin
        scaled_c = acc_c >>> COEF_FRAC;
        dout_d   = DW'(scaled_c);
`ifdef SATURATE_EN
        if (scaled_c > AW'(2047)) begin
            dout_d = 12'h7FF;
        end else if (scaled_c < AW'(-2048)) begin
            dout_d = 12'h800;
        end
`endif
    end

    // Datapath registers. Hlt clears the history and the output at once.
    always_ff @(posedge Clk or negedge Hlt) begin
        if (!Hlt) begin
            for (int unsigned k = 0; k < ZN; k++) begin
                z_q[k] <= '0;
            end
            dout_q <= '0;
        end else begin
            for (int unsigned k = 0; k < ZN; k++) begin
                z_q[k] <= z_d[k];
            end
            dout_q <= dout_d;
        end
    end

    assign Dout = dout_q;

endmodule

// File: tb/tb_fir_transpose.sv
// ----------------------------------------------------------------------------
// tb_fir_transpose
//   Self-checking bench for fir_transpose. The reference model keeps the
//   last NTAPS input samples, each stored with the coefficient bank as it
//   stood when that sample arrived. It forms y = sum_k h_then[k]*x[n-k]
//   with plain arithmetic, then applies the floor shift and the clamp or
//   wrap. Directed cases come first, followed by randomized traffic.
//   Define SATURATE_EN to match the DUT build option.
// ----------------------------------------------------------------------------
module tb_fir_transpose;

    localparam int NTAPS     = 16;
    localparam int COEF_FRAC = 11;
    localparam int NOLIT     = 32'h7FFF_FFFF;

    logic        Clk;
    logic        Hlt;
    logic [11:0] Din;
    logic [11:0] Dout;
    logic [7:0]  write_address;
    logic [11:0] write_value;
    logic        load;
    logic [7:0]  read_address;
    logic [11:0] read_value;

    fir_transpose #(.NTAPS(NTAPS), .COEF_FRAC(COEF_FRAC)) u_dut (
        .Clk           (Clk),
        .Hlt           (Hlt),
        .Din           (Din),
        .Dout          (Dout),
        .write_address (write_address),
        .write_value   (write_value),
        .load          (load),
        .read_address  (read_address),
        .read_value    (read_value)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model state
    int h_m [NTAPS];             // current coefficient bank
    int hx  [NTAPS];             // hx[i] = sample from i edges ago
    int hh  [NTAPS][NTAPS];      // hh[i] = bank when hx[i] arrived
    int exp_dout;
    int n_chk;
    int n_err;

    int lit_imp  [8] = '{50, 100, 150, 200, 0, 0, 0, 0};
    int lit_step [6] = '{50, 150, 300, 500, 500, 500};

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int sx12(input int v);
        int r;
        r = v & 32'hFFF;
        if (r >= 2048) r = r - 4096;
        return r;
    endfunction

    function automatic int model_out();
        longint acc;
        longint s;
        acc = 0;
        for (int i = 0; i < NTAPS; i++) begin
            acc += longint'(hh[i][i]) * longint'(hx[i]);
        end
        s = acc >>> COEF_FRAC;
`ifdef SATURATE_EN
        if (s > 2047) s = 2047;
        if (s < -2048) s = -2048;
        return int'(s);
`else
        return sx12(int'(s & 64'hFFF));
`endif
    endfunction

    // One clock: drive inputs, advance the model, check Dout and the read port.
    task automatic step(input int din, input bit ld, input int wa, input int wv,
                        input int ra, input int lit, input string tag);
        Din           = 12'(din);
        load          = ld;
        write_address = 8'(wa);
        write_value   = 12'(wv);
        if (Hlt) begin
            for (int i = NTAPS - 1; i > 0; i--) begin
                hx[i] = hx[i - 1];
                hh[i] = hh[i - 1];
            end
            hx[0]    = sx12(din);
            hh[0]    = h_m;
            exp_dout = model_out();
        end
        if (ld && wa >= 0 && wa < NTAPS) h_m[wa] = sx12(wv);
        @(posedge Clk);
        #1;
        chk({tag, ".dout"}, sx12(int'(Dout)), exp_dout);
        if (lit != NOLIT) chk({tag, ".lit"}, sx12(int'(Dout)), lit);
        load         = 1'b0;
        read_address = 8'(ra);
        #1;
        chk({tag, ".rv"}, sx12(int'(read_value)), (ra < NTAPS) ? h_m[ra] : 0);
    endtask

    // Assert Hlt between edges. Dout must clear without waiting for a clock.
    task automatic assert_reset(input string tag);
        Hlt = 1'b0;
        #1;
        chk({tag, ".async"}, sx12(int'(Dout)), 0);
        for (int i = 0; i < NTAPS; i++) begin
            hx[i] = 0;
            for (int j = 0; j < NTAPS; j++) hh[i][j] = 0;
        end
        exp_dout = 0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        exp_dout = 0;
        for (int i = 0; i < NTAPS; i++) begin
            h_m[i] = 0;
            hx[i]  = 0;
            for (int j = 0; j < NTAPS; j++) hh[i][j] = 0;
        end
        Hlt = 1'b0;
        Din = '0;
        load = 1'b0;
        write_address = '0;
        write_value = '0;
        read_address = '0;
        #3;
        chk("reset.dout", sx12(int'(Dout)), 0);

        // 1: load coefficients while in reset, then read them back
        for (int i = 0; i < NTAPS; i++) begin
            step(0, 1'b1, i, (i < 4) ? (i + 1) * 100 : 0, 0, NOLIT, "t1.load");
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 1'b0, 0, 0, i, NOLIT, "t1.read");
            chk("t1.rv_lit", sx12(int'(read_value)), (i + 1) * 100);
        end
        step(0, 1'b0, 0, 0, 200, NOLIT, "t1.read200");
        chk("t1.rv200_lit", sx12(int'(read_value)), 0);
        Hlt = 1'b1;

        // 2: impulse response
        for (int i = 0; i < 8; i++) begin
            step((i == 0) ? 1024 : 0, 1'b0, 0, 0, i % 4, lit_imp[i], "t2.imp");
        end

        // 3: step response
        for (int i = 0; i < 6; i++) begin
            step(1024, 1'b0, 0, 0, 0, lit_step[i], "t3.step");
        end

        // 6: rewrite h[1] while the filter runs
        step(1024, 1'b1, 1, -200, 1, NOLIT, "t6.write");
        for (int i = 0; i < 4; i++) begin
            step(1024, 1'b0, 0, 0, 1, (i == 3) ? 300 : NOLIT, "t6.run");
        end
        step(1024, 1'b1, 300, 77, 1, NOLIT, "t6.oob_write");

        // 5: mid-stream reset keeps the coefficients; restore h[1], then impulse
        assert_reset("t5");
        step(0, 1'b1, 1, 200, 1, 0, "t5.inrst");
        for (int i = 0; i < 4; i++) begin
            step(0, 1'b0, 0, 0, i, 0, "t5.readback");
        end
        Hlt = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step((i == 0) ? 1024 : 0, 1'b0, 0, 0, i % 4, lit_imp[i], "t5.imp");
        end

        // 4: large coefficients and a full-scale step
        assert_reset("t4");
        for (int i = 0; i < 4; i++) begin
            step(0, 1'b1, i, 2047, i, 0, "t4.load");
        end
        Hlt = 1'b1;
        for (int i = 0; i < 6; i++) begin
`ifdef SATURATE_EN
            step(2047, 1'b0, 0, 0, 0, (i == 0) ? 2046 : 2047, "t4.sat");
`else
            step(2047, 1'b0, 0, 0, 0, (i == 0) ? 2046 : NOLIT, "t4.wrap");
`endif
        end

        // Randomized traffic: samples, coefficient writes, reads, resets
        for (int n = 0; n < 600; n++) begin
            int din;
            int wa;
            bit ld;
            din = int'($urandom_range(0, 4095)) - 2048;
            ld  = ($urandom_range(0, 7) == 0);
            wa  = ($urandom_range(0, 15) == 0) ? 255 : int'($urandom_range(0, 19));
            if ($urandom_range(0, 59) == 0) begin
                assert_reset("rnd");
                step(din, ld, wa, int'($urandom_range(0, 4095)),
                     int'($urandom_range(0, 23)), NOLIT, "rnd.inrst");
                Hlt = 1'b1;
            end else begin
                step(din, ld, wa, int'($urandom_range(0, 4095)),
                     int'($urandom_range(0, 23)), NOLIT, "rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
